mult_div_unit: RTL

- Iterative multiply/divide unit in the EX stage, beside the combinational ALU.
- Takes over MULT/MULTU/DIV/DIVU so the ALU never needs single-cycle `*` and `/` paths.
- Writes the architectural HI/LO registers; MFHI/MFLO read them, MTHI/MTLO write them.
- Uses a start/busy/done handshake so the hazard unit can stall on MFHI/MFLO while busy.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_datapath.sv | 87 ++++++++
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encodings (also used by the decoder and hazard unit), the
// controller state type and the number of CALC cycles per operation.
package mdu_pkg;

  localparam int MDU_WIDTH       = 32;
  localparam int MDU_CALC_CYCLES = MDU_WIDTH;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Divide ops have op[1] set.
  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops (MULT, DIV) have op[0] clear.
  function automatic logic mdu_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Iteration datapath of the multiply/divide unit.
// Holds the high/low accumulator halves and the latched operand, and performs
// one shift-add (multiply) or restoring subtract-shift (divide) step per cycle.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture unsigned magnitudes and the operation kind
//   step        perform one iteration
//   is_div      operation kind sampled on load
//   mag_a       multiplicand / dividend magnitude
//   mag_b       multiplier / divisor magnitude
//   acc_hi      product high half, or remainder
//   acc_lo      product low half, or quotient
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic             is_div_r;
  logic [WIDTH-1:0] opnd_r;    // multiplicand or divisor
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;

  logic [WIDTH:0]   sum_s;     // multiply partial sum, carry in the top bit
  logic [WIDTH:0]   shift_s;   // divide partial remainder, WIDTH+1 bits wide
  logic [WIDTH:0]   diff_s;    // trial subtraction; top bit set means negative
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;

  // One iteration step for both operation kinds.
  always_comb begin
    sum_s     = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    shift_s   = {acc_hi_r, acc_lo_r[WIDTH-1]};
    diff_s    = shift_s - {1'b0, opnd_r};
    hi_next_s = acc_hi_r;
    lo_next_s = acc_lo_r;
    if (is_div_r) begin
      // The remainder is always below the divisor, so it fits in WIDTH bits.
      if (!diff_s[WIDTH]) begin
        hi_next_s = diff_s[WIDTH-1:0];
        lo_next_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_s = shift_s[WIDTH-1:0];
        lo_next_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift the {carry, hi, lo} accumulator right by one.
      hi_next_s = sum_s[WIDTH:1];
      lo_next_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_r <= 1'b0;
      opnd_r   <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
    end else if (load) begin
      is_div_r <= is_div;
      opnd_r   <= is_div ? mag_b : mag_a;
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= is_div ? mag_a : mag_b;
    end else if (step) begin
      acc_hi_r <= hi_next_s;
      acc_lo_r <= lo_next_s;
    end else begin
      acc_hi_r <= acc_hi_r;
      acc_lo_r <= acc_lo_r;
    end
  end

  assign acc_hi = acc_hi_r;
  assign acc_lo = acc_lo_r;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start, op    launch MULT/MULTU/DIV/DIVU (sampled only when idle)
//   a, b         rs / rt operands
//   mthi, mtlo   write wdata to HI / LO when idle and no start is accepted
//   wdata        move data
//   busy         operation in progress (CALC or FIX)
//   done         one-cycle pulse once HI/LO show an operation's result
//   div_zero     sticky divide-by-zero flag, cleared by the next start
//   hi, lo       HI and LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CALC_CYCLES - 1);

  mdu_state_e         state_r, state_next_s;
  logic [1:0]         op_r;
  logic               prod_neg_r, quot_neg_r, rem_neg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               start_ok_s, is_signed_s, b_zero_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH-1:0]   acc_hi_s, acc_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  // Operand magnitudes and launch qualification.
  always_comb begin
    start_ok_s  = start && (state_r == IDLE);
    is_signed_s = mdu_is_signed(op);
    b_zero_s    = (b == {WIDTH{1'b0}});
    mag_a_s     = (is_signed_s && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    mag_b_s     = (is_signed_s && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
  end

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_ok_s),
    .step   (state_r == CALC),
    .is_div (mdu_is_div(op)),
    .mag_a  (mag_a_s),
    .mag_b  (mag_b_s),
    .acc_hi (acc_hi_s),
    .acc_lo (acc_lo_s)
  );

  // Sign correction applied when leaving FIX.
  always_comb begin
    prod_s   = {acc_hi_s, acc_lo_s};
    fix_hi_s = acc_hi_s;
    fix_lo_s = acc_lo_s;
    if (mdu_is_div(op_r)) begin
      if (mdu_is_signed(op_r) && quot_neg_r) begin
        fix_lo_s = {WIDTH{1'b0}} - acc_lo_s;
      end else begin
        fix_lo_s = acc_lo_s;
      end
      if (mdu_is_signed(op_r) && rem_neg_r) begin
        fix_hi_s = {WIDTH{1'b0}} - acc_hi_s;
      end else begin
        fix_hi_s = acc_hi_s;
      end
    end else begin
      if (mdu_is_signed(op_r) && prod_neg_r) begin
        prod_s = {(2*WIDTH){1'b0}} - prod_s;
      end else begin
        prod_s = {acc_hi_s, acc_lo_s};
      end
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (mdu_is_div(op) && b_zero_s) begin
            state_next_s = FIX;
          end else begin
            state_next_s = CALC;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operation latch, result signs, iteration counter and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 2'b00;
      prod_neg_r <= 1'b0;
      quot_neg_r <= 1'b0;
      rem_neg_r  <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_r == FIX);
      if (start_ok_s) begin
        op_r       <= op;
        prod_neg_r <= a[WIDTH-1] ^ b[WIDTH-1];
        quot_neg_r <= a[WIDTH-1] ^ b[WIDTH-1];
        rem_neg_r  <= a[WIDTH-1];
        cnt_r      <= CNT_LOAD;
        div_zero_r <= mdu_is_div(op) && b_zero_s;
      end else if ((state_r == CALC) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // HI/LO: result load at FIX, architectural moves only while truly idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (state_r == FIX) begin
      if (!div_zero_r) begin
        hi_r <= fix_hi_s;
        lo_r <= fix_lo_s;
      end
    end else if ((state_r == IDLE) && !start) begin
      if (mthi) begin
        hi_r <= wdata;
      end
      if (mtlo) begin
        lo_r <= wdata;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule
